// File: rtl/haz_pkg.sv
// Shared types and constants for the pipeline hazard controller and its busy timer.
package haz_pkg;

  localparam int RF_AW          = 5;
  localparam int MAX_FWD_STAGES = 4;
  localparam int FWD_RF         = 0;

  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] rd;
    logic [RF_AW-1:0] rs1;
    logic [RF_AW-1:0] rs2;
    logic             regwrite;
    logic             memread;
    logic             multi;
  } stage_info_t;

  localparam stage_info_t STAGE_EMPTY = '0;

  // A later stage can feed a source only if it really writes a non-x0 register.
  function automatic logic fwd_hit(input stage_info_t s, input logic [RF_AW-1:0] r);
    return s.valid & s.regwrite & (s.rd != '0) & (s.rd == r);
  endfunction

endpackage

// File: rtl/ex_busy_timer.sv
// Down-counter marking how many more cycles a multi-cycle op still occupies EX.
module ex_busy_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       busy_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, branch flush, multi-cycle EX hold and forwarding selects.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush/hold event counters.
module pipe_hazard_ctrl
  import haz_pkg::*;
#(
  parameter int RF_ADDRESS = 5,
  parameter int FWD_STAGES = 2,
  parameter int MUL_LAT    = 3,
  parameter int FSEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [RF_ADDRESS-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_multi,
  input  logic                  ex_branch_taken,
  output logic                  stall_pc,
  output logic                  flush_ifid,
  output logic                  bubble_idex,
  output logic                  hold_ex,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_hold_cyc,
`endif
  output logic [FSEL_W-1:0]     fwd_a_sel,
  output logic [FSEL_W-1:0]     fwd_b_sel
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  stage_info_t s_q [FWD_STAGES+1];
  stage_info_t id_info;
  logic        busy;
  logic        lu;
  logic        lu_stall;
  logic        load_ex;

  assign id_info = '{valid: id_valid, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                     regwrite: id_regwrite, memread: id_memread, multi: id_multi};

  assign lu = id_valid & s_q[0].valid & s_q[0].memread & (s_q[0].rd != '0) &
              ((id_use_rs1 & (id_rs1 == s_q[0].rd)) | (id_use_rs2 & (id_rs2 == s_q[0].rd)));

  assign hold_ex = s_q[0].valid & s_q[0].multi & busy;

  always_comb begin
    stall_pc    = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    lu_stall    = 1'b0;
    if (ex_branch_taken && !hold_ex) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (hold_ex) begin
      stall_pc    = 1'b1;
    end else if (lu) begin
      stall_pc    = 1'b1;
      bubble_idex = 1'b1;
      lu_stall    = 1'b1;
    end
  end

  assign load_ex = !hold_ex & !bubble_idex & id_valid & id_multi;

  ex_busy_timer u_busy (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load_ex),
    .load_val_i(MUL_LOAD),
    .busy_o    (busy)
  );

  // While EX is held the op stays in S[0]; MEM sees a bubble each held cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= FWD_STAGES; k++) s_q[k] <= STAGE_EMPTY;
    end else begin
      if (hold_ex) begin
        s_q[1] <= STAGE_EMPTY;
      end else begin
        s_q[0] <= (bubble_idex || !id_valid) ? STAGE_EMPTY : id_info;
        s_q[1] <= s_q[0];
      end
      for (int k = 2; k <= FWD_STAGES; k++) s_q[k] <= s_q[k-1];
    end
  end

  // Scan oldest to youngest so the nearest matching stage wins.
  always_comb begin
    fwd_a_sel = FSEL_W'(FWD_RF);
    fwd_b_sel = FSEL_W'(FWD_RF);
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (fwd_hit(s_q[k], s_q[0].rs1)) fwd_a_sel = FSEL_W'(k);
      if (fwd_hit(s_q[k], s_q[0].rs2)) fwd_b_sel = FSEL_W'(k);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_hold_cyc  <= '0;
    end else begin
      if (lu_stall && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush_ifid && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (hold_ex && perf_hold_cyc != '1) perf_hold_cyc <= perf_hold_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (FWD_STAGES=2, MUL_LAT=3).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regwrite, id_memread, id_multi;
  logic       ex_branch_taken;
  logic       stall_pc, flush_ifid, bubble_idex, hold_ex;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_hold_cyc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RF_ADDRESS(5), .FWD_STAGES(2), .MUL_LAT(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rd          (id_rd),
    .id_regwrite    (id_regwrite),
    .id_memread     (id_memread),
    .id_multi       (id_multi),
    .ex_branch_taken(ex_branch_taken),
    .stall_pc       (stall_pc),
    .flush_ifid     (flush_ifid),
    .bubble_idex    (bubble_idex),
    .hold_ex        (hold_ex),
`ifdef HAZ_PERF_CNT_EN
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_hold_cyc  (perf_hold_cyc),
`endif
    .fwd_a_sel      (fwd_a_sel),
    .fwd_b_sel      (fwd_b_sel)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // valid, rd, rs1, rs2, use_rs1, use_rs2, regwrite, memread, multi
  task automatic set_id(input logic v, input int rd, input int rs1, input int rs2,
                        input logic u1, input logic u2, input logic rw,
                        input logic mr, input logic mu);
    id_valid    = v;
    id_rd       = 5'(rd);
    id_rs1      = 5'(rs1);
    id_rs2      = 5'(rs2);
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_regwrite = rw;
    id_memread  = mr;
    id_multi    = mu;
    #1;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", stall_pc, 0);
    chk("rst_flush", flush_ifid, 0);
    chk("rst_bubble", bubble_idex, 0);
    chk("rst_hold", hold_ex, 0);
    chk("rst_fa", fwd_a_sel, 0);
    chk("rst_fb", fwd_b_sel, 0);

    // lw x5,0(x1) ; add x6,x5,x1
    set_id(1, 5, 1, 0, 1, 0, 1, 1, 0);
    tick();
    set_id(1, 6, 5, 1, 1, 1, 1, 0, 0);
    chk("lu_stall", stall_pc, 1);
    chk("lu_bubble", bubble_idex, 1);
    chk("lu_flush", flush_ifid, 0);
    tick();
    chk("lu_released", stall_pc, 0);
    tick();
    chk("lu_fa_memwb", fwd_a_sel, 2);
    chk("lu_fb_rf", fwd_b_sel, 0);
    drain();

    // add x3,x1,x2 ; sub x4,x3,x3
    set_id(1, 3, 1, 2, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 4, 3, 3, 1, 1, 1, 0, 0);
    chk("alu_nostall", stall_pc, 0);
    tick();
    chk("alu_fa", fwd_a_sel, 1);
    chk("alu_fb", fwd_b_sel, 1);
    drain();

    // two writers of x3, then a consumer of x3: nearest wins
    set_id(1, 3, 1, 2, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 3, 3, 0, 1, 0, 1, 0, 0);
    tick();
    set_id(1, 9, 3, 0, 1, 1, 1, 0, 0);
    tick();
    chk("near_fa", fwd_a_sel, 1);
    chk("near_fb_x0", fwd_b_sel, 0);
    drain();

    // write to x0 then read x0
    set_id(1, 0, 1, 2, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 10, 0, 0, 1, 1, 1, 0, 0);
    tick();
    chk("x0_fa", fwd_a_sel, 0);
    chk("x0_fb", fwd_b_sel, 0);
    drain();

    // add x1 ; mul x7,x1,x2 ; add x8,x7,x7
    set_id(1, 1, 2, 2, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 7, 1, 2, 1, 1, 1, 0, 1);
    tick();
    set_id(1, 8, 7, 7, 1, 1, 1, 0, 0);
    chk("mul_hold1", hold_ex, 1);
    chk("mul_stall1", stall_pc, 1);
    chk("mul_bubble1", bubble_idex, 0);
    chk("mul_fa_s1", fwd_a_sel, 1);
    tick();
    chk("mul_hold2", hold_ex, 1);
    chk("mul_fa_s1_empty", fwd_a_sel, 2);
    tick();
    chk("mul_hold_done", hold_ex, 0);
    chk("mul_stall_done", stall_pc, 0);
    chk("mul_fa_rf", fwd_a_sel, 0);
    tick();
    chk("mul_cons_fa", fwd_a_sel, 1);
    chk("mul_cons_fb", fwd_b_sel, 1);
    drain();

    // branch taken together with a load-use
    set_id(1, 5, 1, 0, 1, 0, 1, 1, 0);
    tick();
    set_id(1, 6, 5, 1, 1, 1, 1, 0, 0);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_flush", flush_ifid, 1);
    chk("br_bubble", bubble_idex, 1);
    chk("br_stall", stall_pc, 0);
    ex_branch_taken = 1'b0;
    drain();

    // reset in the middle of a multi-cycle hold
    set_id(1, 1, 2, 2, 1, 1, 1, 0, 0);
    tick();
    set_id(1, 7, 1, 2, 1, 1, 1, 0, 1);
    tick();
    chk("rmid_hold_pre", hold_ex, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rmid_hold", hold_ex, 0);
    chk("rmid_stall", stall_pc, 0);
    chk("rmid_fa", fwd_a_sel, 0);
    chk("rmid_fb", fwd_b_sel, 0);
`ifdef HAZ_PERF_CNT_EN
    chk("rmid_perf_stall", int'(perf_stall_cyc), 0);
    chk("rmid_perf_flush", int'(perf_flush_cnt), 0);
    chk("rmid_perf_hold", int'(perf_hold_cyc), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
